// File: rtl/shot_pool_pkg.sv
// Shared game constants, coordinate type and small arithmetic helpers
// used by the shot pool and its per-slot registers.
package shot_pool_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [9:0] coord_t;

    localparam coord_t SPAWN_OFFSET = 10'd16;

    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
    } shot_t;

    // Widened to 11 bits so the difference never wraps.
    function automatic logic [10:0] abs_diff(input coord_t a, input coord_t b);
        if (a >= b) begin
            return {1'b0, a} - {1'b0, b};
        end
        return {1'b0, b} - {1'b0, a};
    endfunction

    function automatic coord_t spawn_y(input coord_t y);
        if (y >= SPAWN_OFFSET) begin
            return y - SPAWN_OFFSET;
        end
        return '0;
    endfunction

endpackage

// File: rtl/shot_slot.sv
// One shot slot: valid/x/y register, upward move with top-edge exit,
// and the square-hitbox comparator against the target centre.
module shot_slot
    import shot_pool_pkg::*;
#(
    parameter int unsigned SPEED = 8,
    parameter int unsigned HALF  = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   tick,
    input  logic   spawn,
    input  coord_t spawn_x,
    input  coord_t spawn_y,
    input  coord_t tgt_x,
    input  coord_t tgt_y,
    input  logic   tgt_en,
    output logic   valid,
    output coord_t x,
    output coord_t y,
    output logic   hit
);

    shot_t  cur;
    shot_t  nxt;
    coord_t moved_y;

    always_comb begin
        nxt     = cur;
        hit     = 1'b0;
        moved_y = cur.y - coord_t'(SPEED);
        if (cur.valid && tick) begin
            if (cur.y >= coord_t'(SPEED)) begin
                // Collision is judged at the post-move position.
                if (tgt_en && (abs_diff(cur.x, tgt_x) <= 11'(HALF))
                           && (abs_diff(moved_y, tgt_y) <= 11'(HALF))) begin
                    nxt = '0;
                    hit = 1'b1;
                end else begin
                    nxt.y = moved_y;
                end
            end else begin
                nxt = '0;
            end
        end
        // Spawn only targets a free slot, so it never overrides a move.
        if (spawn) begin
            nxt.valid = 1'b1;
            nxt.x     = spawn_x;
            nxt.y     = spawn_y;
        end
        if (clear) begin
            nxt = '0;
            hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign valid = cur.valid;
    assign x     = cur.x;
    assign y     = cur.y;

endmodule

// File: rtl/shot_pool.sv
// Player shot pool: spawn arbitration with cooldown, NSLOT shot slots and
// hit aggregation. Define SHOT_AUTOFIRE_EN to repeat spawns while fire is held.
module shot_pool
    import shot_pool_pkg::*;
#(
    parameter int unsigned NSLOT    = 4,
    parameter int unsigned SPEED    = 8,
    parameter int unsigned COOLDOWN = 6,
    parameter int unsigned HALF     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gamestart,
    input  logic               tick,
    input  logic               fire,
    input  logic [9:0]         reimux,
    input  logic [9:0]         reimuy,
    input  logic [9:0]         tgt_x,
    input  logic [9:0]         tgt_y,
    input  logic               tgt_en,
    output logic [NSLOT-1:0]   shot_valid,
    output logic [NSLOT*10-1:0] shot_x,
    output logic [NSLOT*10-1:0] shot_y,
    output logic               hit,
    output logic [2:0]         hit_cnt
);

    localparam int unsigned CW = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);

    logic             fire_q;
    logic             fire_rise;
    logic [CW-1:0]    cooldown;
    logic             spawn_req;
    logic             spawn_ok;
    logic             found;
    logic [NSLOT-1:0] grant;
    logic [NSLOT-1:0] hit_vec;
    logic [2:0]       hit_sum;
    coord_t           new_y;

    assign fire_rise = fire & ~fire_q;
    assign new_y     = spawn_y(reimuy);

`ifdef SHOT_AUTOFIRE_EN
    assign spawn_req = (fire_rise | fire) && (cooldown == '0) && gamestart;
`else
    assign spawn_req = fire_rise && (cooldown == '0) && gamestart;
`endif

    // Lowest-index free slot wins the spawn.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (!shot_valid[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign spawn_ok = spawn_req && found;

    always_comb begin
        hit_sum = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            hit_sum = hit_sum + 3'(hit_vec[i]);
        end
    end

    // A dropped request (pool full) leaves the cooldown untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q   <= 1'b0;
            cooldown <= '0;
            hit      <= 1'b0;
            hit_cnt  <= '0;
        end else begin
            fire_q <= fire;
            if (!gamestart) begin
                cooldown <= '0;
            end else if (spawn_ok) begin
                cooldown <= CW'(COOLDOWN);
            end else if (tick && (cooldown != '0)) begin
                cooldown <= cooldown - CW'(1);
            end
            hit     <= gamestart && (hit_vec != '0);
            hit_cnt <= gamestart ? hit_sum : 3'd0;
        end
    end

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        shot_slot #(
            .SPEED (SPEED),
            .HALF  (HALF)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clear   (~gamestart),
            .tick    (tick),
            .spawn   (spawn_ok & grant[i]),
            .spawn_x (reimux),
            .spawn_y (new_y),
            .tgt_x   (tgt_x),
            .tgt_y   (tgt_y),
            .tgt_en  (tgt_en),
            .valid   (shot_valid[i]),
            .x       (shot_x[i*10 +: 10]),
            .y       (shot_y[i*10 +: 10]),
            .hit     (hit_vec[i])
        );
    end

endmodule

// File: doc/shot_pool.md
SHOT_POOL -- requirements
Module: shot_pool

Interface
REQ-001 Parameter NSLOT, default 4: number of concurrent player shots.
REQ-002 Parameter SPEED, default 8: pixels a shot rises per tick.
REQ-003 Parameter COOLDOWN, default 6: ticks between successive spawns.
REQ-004 Parameter HALF, default 16: half-width of the square target hitbox, in pixels.
REQ-005 Port clk  in  1: single clock; all state on its rising edge.
REQ-006 Port rst  in  1: reset, synchronous, active-high.
REQ-007 Port gamestart  in  1: high while a game is running; low clears the pool.
REQ-008 Port tick  in  1: one-cycle movement strobe from the game-rate divider.
REQ-009 Port fire  in  1: fire key level.
REQ-010 Port reimux, reimuy  in  10 each: player position.
REQ-011 Port tgt_x, tgt_y  in  10 each: target (boss) centre.
REQ-012 Port tgt_en  in  1: target is alive and hittable.
REQ-013 Port shot_valid  out  NSLOT: per-slot active flag.
REQ-014 Port shot_x, shot_y  out  NSLOT*10 each: packed per-slot coordinates; slot i occupies bits [10i+9:10i].
REQ-015 Port hit  out  1: one-cycle pulse when one or more shots hit on a tick.
REQ-016 Port hit_cnt  out  3: number of shots that hit on that tick; valid only while hit is high.

Function
REQ-017 The fire rising edge SHALL be fire & ~fire_q, where fire_q is fire registered once.
REQ-018 A spawn request SHALL occur on a fire rising edge when the cooldown counter is 0 and gamestart is 1.
REQ-019 A spawn SHALL fill the lowest-index free slot with x = reimux and y = reimuy - 16, saturating at 0.
REQ-020 If no slot is free, the request SHALL be dropped and the cooldown SHALL NOT reload.
REQ-021 A successful spawn SHALL reload the cooldown to COOLDOWN.
REQ-022 The cooldown SHALL decrement by 1 on each tick while nonzero.
REQ-023 On tick, every active slot with y >= SPEED SHALL subtract SPEED from y; any other active slot SHALL free (top-edge exit).
REQ-024 On tick, after the move, an active slot with tgt_en = 1, |x - tgt_x| <= HALF and |y - tgt_y| <= HALF SHALL free.
REQ-025 On the cycle after such a tick, hit SHALL be high and hit_cnt SHALL equal the number of slots freed by collision.
REQ-026 Distance comparisons SHALL use 11-bit unsigned differences; no wrap-around.
REQ-027 If a spawn and a tick coincide, the tick SHALL apply to existing slots first; the new shot SHALL NOT move or be collision-checked on that tick.
REQ-028 All outputs SHALL be registered; shot_valid of a spawned slot SHALL rise one cycle after the spawn-request cycle.
REQ-029 A freed slot SHALL hold shot_x and shot_y at 0.
REQ-030 When gamestart is 0, all slots and the cooldown SHALL clear, and hit SHALL be 0, in the following cycle.

Reset
REQ-031 On rst, shot_valid, shot_x, shot_y, hit, hit_cnt, the cooldown and fire_q SHALL all be 0.
REQ-032 rst asserted mid-flight SHALL discard all shots; no hit pulse SHALL be emitted for a tick in the same cycle as rst.

Configuration
REQ-033 Macro SHOT_AUTOFIRE_EN defined: while fire is held, a spawn request SHALL also occur whenever the cooldown is 0, giving one shot per COOLDOWN ticks.
REQ-034 Macro SHOT_AUTOFIRE_EN undefined: only rising edges SHALL request spawns.

Structure
REQ-035 A shared game package SHALL hold SCREEN_W = 640, SCREEN_H = 480, the 10-bit coordinate type and SPAWN_OFFSET = 16.
REQ-036 One sub-module, shot_slot, SHALL hold a single slot's valid/x/y register, its move and exit logic and its hit comparator; it is instantiated NSLOT times.
REQ-037 The free-slot priority encoder and the hit popcount SHALL live in shot_pool.

Verification
REQ-038 Single shot: reimux = 300, reimuy = 400, one fire edge -> slot0 at (300, 384); after 10 ticks y = 304.
REQ-039 Full pool: 5 edges, each spaced by COOLDOWN ticks, with no exits -> slots 0-3 valid; 5th dropped with no cooldown reload; next edge spawns as soon as a slot frees.
REQ-040 Hit: tgt at (300, 300), tgt_en = 1, shot at (300, 316); tick -> y = 308, slot freed, hit = 1 and hit_cnt = 1 for exactly one cycle.
REQ-041 Double hit: two shots inside the hitbox on the same tick -> hit_cnt = 2; with tgt_en = 0 -> no hit and both continue.
REQ-042 Top exit and coincidence: shot at y = 5 on tick -> freed; spawn on the same cycle as tick -> new shot unmoved.
REQ-043 Mid-flight abort: 3 shots active, pulse rst (and separately drop gamestart) -> all shot_valid = 0 next cycle, hit = 0; autofire build: fire held 20 ticks -> 3 or 4 spawns at 6-tick spacing.
